redmule_exp_mlane_buffer: RTL and testbench

Multi-lane exponent prefetch buffer for RedMulE MX datapaths. Unpacks compact exponent beats from the streamer into a circular store and presents up to NUM_LANES exponents per cycle to the engine. A replay mark lets a shared exponent window be re-read for several passes without a re-fetch. Partial tail beats are supported, and the full buffer capacity is usable.

---
 rtl/redmule_pkg.sv | 18 +
 rtl/redmule_exp_mlane_buffer_if.sv | 40 ++++
 rtl/redmule_exp_buf_lane_mux.sv | 25 ++
 rtl/redmule_exp_mlane_buffer.sv | 114 +++++++++++
 tb/tb_redmule_exp_mlane_buffer.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/redmule_pkg.sv
// Shared RedMulE types and helpers for the exponent prefetch buffer and its register path.
package redmule_pkg;

  localparam int unsigned EXP_BUF_PTR_W = 16;

  typedef logic [EXP_BUF_PTR_W-1:0] exp_buf_ptr_t;

  typedef struct packed {
    exp_buf_ptr_t avail;
    logic         err;
  } exp_buf_status_t;

  function automatic int unsigned exps_per_beat(input int unsigned beat_width,
                                                input int unsigned exp_width);
    return beat_width / exp_width;
  endfunction

endpackage

// File: rtl/redmule_exp_mlane_buffer_if.sv
// Streamer-side beat input and engine-side lane-group output of the exponent buffer.
interface redmule_exp_mlane_buffer_if #(
  parameter int unsigned EXP_WIDTH    = 8,
  parameter int unsigned BEAT_WIDTH   = 512,
  parameter int unsigned NUM_LANES    = 4,
  parameter int unsigned BUFFER_DEPTH = 512
);
  import redmule_pkg::*;

  localparam int unsigned EPB    = exps_per_beat(BEAT_WIDTH, EXP_WIDTH);
  localparam int unsigned CNT_W  = $clog2(EPB + 1);
  localparam int unsigned LANE_W = $clog2(NUM_LANES + 1);
  localparam int unsigned PTR_W  = $clog2(BUFFER_DEPTH) + 1;

  logic                           in_valid_i;
  logic                           in_ready_o;
  logic [BEAT_WIDTH-1:0]          in_data_i;
  logic [CNT_W-1:0]               in_cnt_i;
  logic                           drain_i;
  logic                           replay_en_i;
  logic                           mark_i;
  logic                           rewind_i;
  logic [NUM_LANES*EXP_WIDTH-1:0] data_o;
  logic [LANE_W-1:0]              lanes_o;
  logic                           valid_o;
  logic                           consume_i;
  logic [PTR_W-1:0]               avail_o;
  logic                           err_o;

  modport master (
    output in_valid_i, in_data_i, in_cnt_i, drain_i, replay_en_i, mark_i, rewind_i, consume_i,
    input  in_ready_o, data_o, lanes_o, valid_o, avail_o, err_o
  );

  modport slave (
    input  in_valid_i, in_data_i, in_cnt_i, drain_i, replay_en_i, mark_i, rewind_i, consume_i,
    output in_ready_o, data_o, lanes_o, valid_o, avail_o, err_o
  );

endinterface

// File: rtl/redmule_exp_buf_lane_mux.sv
// Wrapped NUM_LANES-way read crossbar; lanes at or above the valid lane count read as zero.
module redmule_exp_buf_lane_mux #(
  parameter  int unsigned EXP_WIDTH    = 8,
  parameter  int unsigned BUFFER_DEPTH = 512,
  parameter  int unsigned NUM_LANES    = 4,
  localparam int unsigned IDX_W        = $clog2(BUFFER_DEPTH),
  localparam int unsigned LANE_W       = $clog2(NUM_LANES + 1)
) (
  input  logic [EXP_WIDTH-1:0]           mem [BUFFER_DEPTH],
  input  logic [IDX_W-1:0]               rd_idx,
  input  logic [LANE_W-1:0]              lanes,
  output logic [NUM_LANES*EXP_WIDTH-1:0] data
);

  always_comb begin
    data = '0;
    for (int j = 0; j < NUM_LANES; j++) begin
      // index arithmetic is IDX_W wide, so a group past the last entry wraps to entry 0
      if (j < int'(lanes)) begin
        data[j*EXP_WIDTH +: EXP_WIDTH] = mem[rd_idx + IDX_W'(j)];
      end
    end
  end

endmodule

// File: rtl/redmule_exp_mlane_buffer.sv
// Circular exponent store: beats in, up to NUM_LANES exponents out per cycle, replay via mark/rewind.
// Write-to-read latency 1 cycle; in_ready_o is registered from next-state free space.
module redmule_exp_mlane_buffer
  import redmule_pkg::*;
#(
  parameter int unsigned EXP_WIDTH    = 8,
  parameter int unsigned BUFFER_DEPTH = 512,
  parameter int unsigned BEAT_WIDTH   = 512,
  parameter int unsigned NUM_LANES    = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clear_i,
  redmule_exp_mlane_buffer_if.slave bus
);

  localparam int unsigned EPB    = exps_per_beat(BEAT_WIDTH, EXP_WIDTH);
  localparam int unsigned IDX_W  = $clog2(BUFFER_DEPTH);
  localparam int unsigned PTR_W  = IDX_W + 1;
  localparam int unsigned CNT_W  = $clog2(EPB + 1);
  localparam int unsigned LANE_W = $clog2(NUM_LANES + 1);

  logic [EXP_WIDTH-1:0] mem_q [BUFFER_DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q, mark_ptr_q;
  logic [PTR_W-1:0]  wr_ptr_d, rd_ptr_d, mark_ptr_d;
  logic [PTR_W-1:0]  avail, free_d;
  logic [LANE_W-1:0] lanes;
  logic [CNT_W-1:0]  wr_cnt;
  logic              in_ready_q, in_ready_d;
  logic              err_q, err_d;
  logic              wr_fire, cnt_over, grp_vld, rewind_ok, cons_ok, soft_rst;

  assign soft_rst = rst_i || clear_i;

  always_comb begin
    avail      = wr_ptr_q - rd_ptr_q;
    lanes      = (avail >= PTR_W'(NUM_LANES)) ? LANE_W'(NUM_LANES) : LANE_W'(avail);
    grp_vld    = (avail >= PTR_W'(NUM_LANES)) || (bus.drain_i && (avail != '0));

    wr_fire    = bus.in_valid_i && in_ready_q;
    cnt_over   = bus.in_cnt_i > CNT_W'(EPB);
    wr_cnt     = cnt_over ? CNT_W'(EPB) : bus.in_cnt_i;
    wr_ptr_d   = wr_fire ? (wr_ptr_q + PTR_W'(wr_cnt)) : wr_ptr_q;

    // rewind wins over a same-cycle consume and mark
    rewind_ok  = bus.rewind_i && bus.replay_en_i;
    cons_ok    = bus.consume_i && grp_vld && !rewind_ok;
    rd_ptr_d   = rd_ptr_q;
    if (rewind_ok) begin
      rd_ptr_d = mark_ptr_q;
    end else if (cons_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(lanes);
    end

    mark_ptr_d = mark_ptr_q;
    if (!bus.replay_en_i || (bus.mark_i && !rewind_ok)) begin
      mark_ptr_d = rd_ptr_d;
    end

    // entries from the mark onward are protected, so free space is measured from the mark
    free_d     = PTR_W'(BUFFER_DEPTH) - (wr_ptr_d - mark_ptr_d);
    in_ready_d = free_d >= PTR_W'(EPB);

    err_d      = err_q
               || (bus.consume_i && !grp_vld)
               || (bus.rewind_i && !bus.replay_en_i)
               || (wr_fire && cnt_over);
  end

  always_ff @(posedge clk_i) begin
    if (soft_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mark_ptr_q <= '0;
      err_q      <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      mark_ptr_q <= mark_ptr_d;
      err_q      <= err_d;
      in_ready_q <= in_ready_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_fire && !soft_rst) begin
      for (int i = 0; i < EPB; i++) begin
        if (i < int'(wr_cnt)) begin
          mem_q[wr_ptr_q[IDX_W-1:0] + IDX_W'(i)] <= bus.in_data_i[i*EXP_WIDTH +: EXP_WIDTH];
        end
      end
    end
  end

  redmule_exp_buf_lane_mux #(
    .EXP_WIDTH    (EXP_WIDTH),
    .BUFFER_DEPTH (BUFFER_DEPTH),
    .NUM_LANES    (NUM_LANES)
  ) i_lane_mux (
    .mem    (mem_q),
    .rd_idx (rd_ptr_q[IDX_W-1:0]),
    .lanes  (lanes),
    .data   (bus.data_o)
  );

  assign bus.in_ready_o = in_ready_q;
  assign bus.valid_o    = grp_vld;
  assign bus.lanes_o    = lanes;
  assign bus.avail_o    = avail;
  assign bus.err_o      = err_q;

endmodule

// File: tb/tb_redmule_exp_mlane_buffer.sv
// Directed checks of the exponent buffer: fill, wrap, tail, replay, errors and reset.
module tb_redmule_exp_mlane_buffer;

  localparam int unsigned EXP_WIDTH    = 8;
  localparam int unsigned BUFFER_DEPTH = 128;
  localparam int unsigned BEAT_WIDTH   = 512;
  localparam int unsigned NUM_LANES    = 4;
  localparam int unsigned EPB          = BEAT_WIDTH / EXP_WIDTH;

  logic clk_i   = 1'b0;
  logic rst_i   = 1'b1;
  logic clear_i = 1'b0;

  int checks = 0;
  int errors = 0;

  redmule_exp_mlane_buffer_if #(
    .EXP_WIDTH    (EXP_WIDTH),
    .BEAT_WIDTH   (BEAT_WIDTH),
    .NUM_LANES    (NUM_LANES),
    .BUFFER_DEPTH (BUFFER_DEPTH)
  ) bus ();

  redmule_exp_mlane_buffer #(
    .EXP_WIDTH    (EXP_WIDTH),
    .BUFFER_DEPTH (BUFFER_DEPTH),
    .BEAT_WIDTH   (BEAT_WIDTH),
    .NUM_LANES    (NUM_LANES)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (clear_i),
    .bus     (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic set_beat(input int base, input int cnt);
    for (int i = 0; i < EPB; i++) begin
      bus.in_data_i[i*EXP_WIDTH +: EXP_WIDTH] = 8'(base + i);
    end
    bus.in_cnt_i = 7'(cnt);
  endtask

  task automatic push(input int base, input int cnt);
    set_beat(base, cnt);
    bus.in_valid_i = 1'b1;
    tick();
    bus.in_valid_i = 1'b0;
    settle();
  endtask

  task automatic pop();
    bus.consume_i = 1'b1;
    tick();
    bus.consume_i = 1'b0;
    settle();
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    settle();
  endtask

  function automatic logic [31:0] seq4(input int b);
    return {8'(b + 3), 8'(b + 2), 8'(b + 1), 8'(b)};
  endfunction

  initial begin
    bus.in_valid_i  = 1'b0;
    bus.in_data_i   = '0;
    bus.in_cnt_i    = '0;
    bus.drain_i     = 1'b0;
    bus.replay_en_i = 1'b0;
    bus.mark_i      = 1'b0;
    bus.rewind_i    = 1'b0;
    bus.consume_i   = 1'b0;

    // reset state
    tick();
    rst_i = 1'b0;
    settle();
    chk("rst_ready", bus.in_ready_o, 1);
    chk("rst_valid", bus.valid_o, 0);
    chk("rst_lanes", bus.lanes_o, 0);
    chk("rst_data",  bus.data_o, 0);
    chk("rst_avail", bus.avail_o, 0);
    chk("rst_err",   bus.err_o, 0);

    // fill to full
    push(0, 64);
    chk("fill_ready1", bus.in_ready_o, 1);
    chk("fill_avail1", bus.avail_o, 64);
    push(64, 64);
    chk("fill_ready2", bus.in_ready_o, 0);
    chk("fill_avail2", bus.avail_o, 128);
    chk("fill_data0",  bus.data_o, seq4(0));
    pop();
    chk("fill_ready_pop", bus.in_ready_o, 0);
    chk("fill_avail_pop", bus.avail_o, 124);
    chk("fill_data1",     bus.data_o, seq4(4));

    // wrap: A fills 0..63, B pushes 2 entries, C straddles entry 127
    do_reset();
    push(0, 64);
    for (int k = 0; k < 16; k++) begin
      chk("wrap_a_data", bus.data_o, seq4(4 * k));
      pop();
    end
    chk("wrap_a_empty", bus.avail_o, 0);
    push(200, 2);
    bus.drain_i = 1'b1;
    settle();
    chk("wrap_b_valid", bus.valid_o, 1);
    chk("wrap_b_lanes", bus.lanes_o, 2);
    chk("wrap_b_data",  bus.data_o, 32'h0000_C9C8);
    pop();
    bus.drain_i = 1'b0;
    settle();
    push(128, 64);
    chk("wrap_c_ready", bus.in_ready_o, 1);
    chk("wrap_c_avail", bus.avail_o, 64);
    for (int k = 0; k < 15; k++) begin
      chk("wrap_c_data", bus.data_o, seq4(128 + 4 * k));
      pop();
    end
    chk("wrap_straddle_data",  bus.data_o, seq4(188));
    chk("wrap_straddle_lanes", bus.lanes_o, 4);
    chk("wrap_straddle_avail", bus.avail_o, 4);
    pop();
    chk("wrap_after_data", bus.data_o, 0);

    // partial tail
    do_reset();
    push(10, 6);
    chk("tail_valid1", bus.valid_o, 1);
    chk("tail_lanes1", bus.lanes_o, 4);
    chk("tail_data1",  bus.data_o, seq4(10));
    pop();
    chk("tail_valid2", bus.valid_o, 0);
    chk("tail_lanes2", bus.lanes_o, 2);
    chk("tail_avail2", bus.avail_o, 2);
    bus.drain_i = 1'b1;
    settle();
    chk("tail_valid_drain", bus.valid_o, 1);
    chk("tail_data_drain",  bus.data_o, 32'h0000_0F0E);
    pop();
    bus.drain_i = 1'b0;
    settle();
    chk("tail_empty", bus.avail_o, 0);

    // replay
    do_reset();
    bus.replay_en_i = 1'b1;
    bus.mark_i = 1'b1;
    tick();
    bus.mark_i = 1'b0;
    settle();
    push(0, 64);
    push(64, 64);
    chk("rep_full_ready", bus.in_ready_o, 0);
    for (int k = 0; k < 8; k++) pop();
    chk("rep_avail8",   bus.avail_o, 96);
    chk("rep_blocked",  bus.in_ready_o, 0);
    bus.rewind_i  = 1'b1;
    bus.consume_i = 1'b1;
    tick();
    bus.rewind_i  = 1'b0;
    bus.consume_i = 1'b0;
    settle();
    chk("rep_rewind_avail", bus.avail_o, 128);
    chk("rep_rewind_err",   bus.err_o, 0);
    for (int k = 0; k < 8; k++) begin
      chk("rep_reread", bus.data_o, seq4(4 * k));
      pop();
    end
    for (int k = 0; k < 8; k++) pop();
    chk("rep_avail64",     bus.avail_o, 64);
    chk("rep_still_block", bus.in_ready_o, 0);
    bus.mark_i = 1'b1;
    tick();
    bus.mark_i = 1'b0;
    settle();
    chk("rep_mark_release", bus.in_ready_o, 1);
    chk("rep_mark_data",    bus.data_o, seq4(64));
    bus.replay_en_i = 1'b0;

    // errors and reset
    do_reset();
    bus.consume_i = 1'b1;
    tick();
    bus.consume_i = 1'b0;
    settle();
    chk("err_consume_empty", bus.err_o, 1);
    chk("err_consume_avail", bus.avail_o, 0);
    set_beat(0, 64);
    bus.in_valid_i = 1'b1;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    bus.in_valid_i = 1'b0;
    settle();
    chk("mid_rst_ready", bus.in_ready_o, 1);
    chk("mid_rst_valid", bus.valid_o, 0);
    chk("mid_rst_avail", bus.avail_o, 0);
    chk("mid_rst_err",   bus.err_o, 0);
    tick();
    chk("mid_rst_dropped", bus.avail_o, 0);
    bus.rewind_i = 1'b1;
    tick();
    bus.rewind_i = 1'b0;
    settle();
    chk("err_rewind_noreplay", bus.err_o, 1);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    settle();
    chk("clear_err", bus.err_o, 0);
    push(32, 65);
    chk("over_err",   bus.err_o, 1);
    chk("over_avail", bus.avail_o, 64);
    chk("over_data",  bus.data_o, seq4(32));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
